// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings for the universal shift register
// Purpose: mode and shift-direction encodings used by shift_universal and its counter.
// Ports: none (package).
package shift_pkg;

  // Operation select, 2 bits
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Shift direction as tracked by the word counter
  typedef enum logic {
    DIR_R = 1'b0,
    DIR_L = 1'b1
  } dir_t;

  // Width of the shift counter for a given register width
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shift_universal_if.sv
// rtl/shift_universal_if.sv - control/data bundle of the universal shift register
// Purpose: groups operation controls, serial/parallel inputs and register outputs.
// Signals:
//   en, mode, sin_r, sin_l, pdata : driven by the master (controller/bench)
//   q, sout_r, sout_l, cnt, word_valid : driven by the slave (shift_universal)
// Modports: master (drives controls), slave (the shift register).
interface shift_universal_if #(
  parameter int WIDTH = 5
);
  import shift_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  logic             en;
  logic [1:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pdata;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    cnt;
  logic             word_valid;

  modport master (
    output en, mode, sin_r, sin_l, pdata,
    input  q, sout_r, sout_l, cnt, word_valid
  );

  modport slave (
    input  en, mode, sin_r, sin_l, pdata,
    output q, sout_r, sout_l, cnt, word_valid
  );

endinterface

// File: rtl/shift_word_counter.sv
// rtl/shift_word_counter.sv - shift counter and word-complete strobe
// Purpose: counts shifts in the current direction modulo WIDTH and pulses
//   o_word_valid for one cycle after the WIDTH-th shift of a word.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   i_shift      a shift (either direction) happens on this edge
//   i_dir        direction of that shift (DIR_R / DIR_L)
//   i_clear      parallel load: restart the word, keep last direction
//   o_cnt        shifts completed in the current word, 0..WIDTH-1
//   o_word_valid registered one-cycle word-complete pulse
module shift_word_counter
  import shift_pkg::*;
#(
  parameter int WIDTH = 5,
  localparam int CW   = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_shift,
  input  dir_t          i_dir,
  input  logic          i_clear,
  output logic [CW-1:0] o_cnt,
  output logic          o_word_valid
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          r_word_valid;
  dir_t          r_last_dir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_word_valid <= 1'b0;
      r_last_dir   <= DIR_R;
    end else if (i_clear) begin
      r_cnt        <= '0;
      r_word_valid <= 1'b0;
    end else if (i_shift) begin
      if (i_dir == r_last_dir) begin
        // Wrap modulo WIDTH, not modulo 2^CW
        if (r_cnt == CNT_MAX) begin
          r_cnt        <= '0;
          r_word_valid <= 1'b1;
        end else begin
          r_cnt        <= r_cnt + CNT_ONE;
          r_word_valid <= 1'b0;
        end
      end else begin
        // Reversal abandons the partial word; this shift is the first of a new one
        r_cnt        <= CNT_ONE;
        r_last_dir   <= i_dir;
        r_word_valid <= 1'b0;
      end
    end else begin
      r_word_valid <= 1'b0;
    end
  end

  assign o_cnt        = r_cnt;
  assign o_word_valid = r_word_valid;

endmodule

// File: rtl/shift_universal.sv
// rtl/shift_universal.sv - parametrised universal shift register
// Purpose: hold / shift right / shift left / parallel load register with
//   serial outputs at both ends, a per-word shift counter and a word strobe.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    shift_universal_if.slave: en, mode, sin_r, sin_l, pdata in;
//          q, sout_r, sout_l, cnt, word_valid out
module shift_universal
  import shift_pkg::*;
#(
  parameter int               WIDTH       = 5,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              CW          = cnt_width(WIDTH)
) (
  input logic               clk,
  input logic               reset,
  shift_universal_if.slave  bus
);

  logic [WIDTH-1:0] r_q;
  logic [1:0]       w_op;
  logic             w_shift;
  dir_t             w_dir;
  logic             w_clear;
  logic [CW-1:0]    w_cnt;
  logic             w_word_valid;

  // en=0 is indistinguishable from HOLD
  assign w_op    = bus.en ? bus.mode : MODE_HOLD;
  assign w_shift = (w_op == MODE_SHR) || (w_op == MODE_SHL);
  assign w_dir   = (w_op == MODE_SHL) ? DIR_L : DIR_R;
  assign w_clear = (w_op == MODE_LOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= RESET_VALUE;
    end else begin
      case (w_op)
        MODE_SHR:  r_q <= {bus.sin_r, r_q[WIDTH-1:1]};
        MODE_SHL:  r_q <= {r_q[WIDTH-2:0], bus.sin_l};
        MODE_LOAD: r_q <= bus.pdata;
        default:   r_q <= r_q;
      endcase
    end
  end

  shift_word_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk          (clk),
    .reset        (reset),
    .i_shift      (w_shift),
    .i_dir        (w_dir),
    .i_clear      (w_clear),
    .o_cnt        (w_cnt),
    .o_word_valid (w_word_valid)
  );

  assign bus.q          = r_q;
  assign bus.sout_r     = r_q[0];
  assign bus.sout_l     = r_q[WIDTH-1];
  assign bus.cnt        = w_cnt;
  assign bus.word_valid = w_word_valid;

endmodule

// File: tb/tb_shift_universal.sv
// tb/tb_shift_universal.sv - self-checking bench for shift_universal
module tb_shift_universal;
  import shift_pkg::*;

  localparam int W = 5;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  shift_universal_if #(.WIDTH(W)) bus();

  shift_universal #(
    .WIDTH       (W),
    .RESET_VALUE (5'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       sin_r;
    logic       sin_l;
    logic [4:0] pdata;
    logic [4:0] exp_q;
    logic [2:0] exp_cnt;
    logic       exp_wv;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: total shifts in the current same-direction run
  logic [4:0] m_q;
  int         m_run;
  int         m_dir;
  logic       m_wv;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] mode, input logic sr,
                       input logic sl, input logic [4:0] pd);
    bus.en    = en;
    bus.mode  = mode;
    bus.sin_r = sr;
    bus.sin_l = sl;
    bus.pdata = pd;
  endtask

  function automatic vec_t mk(input logic en, input logic [1:0] mode, input logic sr,
                              input logic sl, input logic [4:0] pd, input logic [4:0] q,
                              input logic [2:0] c, input logic wv);
    vec_t v;
    v.en = en; v.mode = mode; v.sin_r = sr; v.sin_l = sl; v.pdata = pd;
    v.exp_q = q; v.exp_cnt = c; v.exp_wv = wv;
    return v;
  endfunction

  task automatic model_reset();
    m_q = 5'd0; m_run = 0; m_dir = 0; m_wv = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [1:0] mode, input logic sr,
                            input logic sl, input logic [4:0] pd);
    int d;
    if (!en || mode == MODE_HOLD) begin
      m_wv = 1'b0;
    end else if (mode == MODE_LOAD) begin
      m_q = pd; m_run = 0; m_wv = 1'b0;
    end else begin
      d = (mode == MODE_SHL) ? 1 : 0;
      if (d == 0) m_q = 5'((int'(m_q) / 2) + (sr ? 16 : 0));
      else        m_q = 5'(((int'(m_q) * 2) % 32) + (sl ? 1 : 0));
      if (d != m_dir) begin
        m_dir = d; m_run = 1; m_wv = 1'b0;
      end else begin
        m_run++;
        m_wv = (m_run % W) == 0;
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    drive(1'b0, MODE_HOLD, 1'b0, 1'b0, 5'd0);
    tick();
    check("rst_q", int'(bus.q), 0);
    check("rst_cnt", int'(bus.cnt), 0);
    check("rst_wv", int'(bus.word_valid), 0);
    reset = 1'b0;

    // SHR 1,0,1,1,0; LOAD 0; SHL 1,1,0,0,1; LOAD on pulse cycle; SHR x3; freeze; reversal
    vecs.push_back(mk(1, MODE_SHR,  1, 0, 0,  5'd16, 1, 0));
    vecs.push_back(mk(1, MODE_SHR,  0, 0, 0,  5'd8,  2, 0));
    vecs.push_back(mk(1, MODE_SHR,  1, 0, 0,  5'd20, 3, 0));
    vecs.push_back(mk(1, MODE_SHR,  1, 0, 0,  5'd26, 4, 0));
    vecs.push_back(mk(1, MODE_SHR,  0, 0, 0,  5'd13, 0, 1));
    vecs.push_back(mk(1, MODE_LOAD, 0, 0, 0,  5'd0,  0, 0));
    vecs.push_back(mk(1, MODE_SHL,  0, 1, 0,  5'd1,  1, 0));
    vecs.push_back(mk(1, MODE_SHL,  0, 1, 0,  5'd3,  2, 0));
    vecs.push_back(mk(1, MODE_SHL,  0, 0, 0,  5'd6,  3, 0));
    vecs.push_back(mk(1, MODE_SHL,  0, 0, 0,  5'd12, 4, 0));
    vecs.push_back(mk(1, MODE_SHL,  0, 1, 0,  5'd25, 0, 1));
    vecs.push_back(mk(1, MODE_LOAD, 0, 0, 18, 5'd18, 0, 0));
    vecs.push_back(mk(1, MODE_SHR,  0, 0, 0,  5'd9,  1, 0));
    vecs.push_back(mk(1, MODE_SHR,  0, 0, 0,  5'd4,  2, 0));
    vecs.push_back(mk(1, MODE_SHR,  0, 0, 0,  5'd2,  3, 0));
    vecs.push_back(mk(1, MODE_HOLD, 1, 1, 31, 5'd2,  3, 0));
    vecs.push_back(mk(1, MODE_HOLD, 1, 1, 31, 5'd2,  3, 0));
    vecs.push_back(mk(0, MODE_SHR,  1, 1, 31, 5'd2,  3, 0));
    vecs.push_back(mk(0, MODE_LOAD, 1, 1, 31, 5'd2,  3, 0));
    vecs.push_back(mk(1, MODE_SHL,  0, 1, 0,  5'd5,  1, 0));
    vecs.push_back(mk(1, MODE_SHL,  0, 0, 0,  5'd10, 2, 0));
    vecs.push_back(mk(1, MODE_SHL,  0, 0, 0,  5'd20, 3, 0));
    vecs.push_back(mk(1, MODE_SHL,  0, 0, 0,  5'd8,  4, 0));
    vecs.push_back(mk(1, MODE_SHL,  0, 0, 0,  5'd16, 0, 1));
    vecs.push_back(mk(1, MODE_HOLD, 0, 0, 0,  5'd16, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].mode, vecs[i].sin_r, vecs[i].sin_l, vecs[i].pdata);
      tick();
      check($sformatf("vec%0d_q", i), int'(bus.q), int'(vecs[i].exp_q));
      check($sformatf("vec%0d_cnt", i), int'(bus.cnt), int'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_wv", i), int'(bus.word_valid), int'(vecs[i].exp_wv));
      check($sformatf("vec%0d_sout_r", i), int'(bus.sout_r), int'(vecs[i].exp_q[0]));
      check($sformatf("vec%0d_sout_l", i), int'(bus.sout_l), int'(vecs[i].exp_q[4]));
    end

    // 10 continuous SHL after a load: pulses only after edges 5 and 10
    drive(1, MODE_LOAD, 0, 0, 5'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, MODE_SHL, 0, 1'($urandom_range(0, 1)), 5'd0);
      tick();
      check($sformatf("b2b_wv%0d", i), int'(bus.word_valid), (i == 4 || i == 9) ? 1 : 0);
      check($sformatf("b2b_cnt%0d", i), int'(bus.cnt), (i + 1) % W);
    end
    // LOAD during the pulse cycle
    drive(1, MODE_LOAD, 0, 0, 5'd21);
    tick();
    check("ldpulse_q", int'(bus.q), 21);
    check("ldpulse_cnt", int'(bus.cnt), 0);
    check("ldpulse_wv", int'(bus.word_valid), 0);

    // Asynchronous reset between edges, one shift short of a word
    drive(1, MODE_LOAD, 0, 0, 5'd31);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, MODE_SHR, 1, 0, 5'd0);
      tick();
    end
    check("pre_rst_cnt", int'(bus.cnt), 4);
    #3 reset = 1'b1;
    #1;
    check("arst_q", int'(bus.q), 0);
    check("arst_cnt", int'(bus.cnt), 0);
    check("arst_wv", int'(bus.word_valid), 0);
    #1 reset = 1'b0;
    tick();
    check("post_rst_cnt", int'(bus.cnt), 1);
    check("post_rst_wv", int'(bus.word_valid), 0);
    check("post_rst_q", int'(bus.q), 16);

    // Randomised run against the reference model
    #3 reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      logic       en;
      logic [1:0] md;
      logic       sr;
      logic       sl;
      logic [4:0] pd;
      en = ($urandom_range(0, 7) != 0);
      md = ($urandom_range(0, 9) == 0) ? MODE_LOAD : 2'($urandom_range(0, 2));
      sr = 1'($urandom_range(0, 1));
      sl = 1'($urandom_range(0, 1));
      pd = 5'($urandom_range(0, 31));
      drive(en, md, sr, sl, pd);
      model_step(en, md, sr, sl, pd);
      tick();
      check($sformatf("rnd%0d_q", i), int'(bus.q), int'(m_q));
      check($sformatf("rnd%0d_cnt", i), int'(bus.cnt), m_run % W);
      check($sformatf("rnd%0d_wv", i), int'(bus.word_valid), int'(m_wv));
      check($sformatf("rnd%0d_sout", i), int'({bus.sout_l, bus.sout_r}), int'({m_q[4], m_q[0]}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
